// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle between N producers, the selector and one downstream consumer.
interface mux_nto1_rr_if #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        mux_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_sel;

    // Producers/consumer/control side.
    modport master (
        output in_data, in_valid, mode, select, out_ready,
        input  in_ready, mux_out, out_valid, out_sel
    );

    // Selector side.
    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
        output in_ready, mux_out, out_valid, out_sel
    );
endinterface

// File: rtl/mux_nto1_rr.sv
// N-to-1 selector with fixed or round-robin grant and a one-word registered output stage.
module mux_nto1_rr #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic         clk,
    input  logic         rst,
    mux_nto1_rr_if.slave bus
);
    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam int unsigned IW = SEL_W + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SEL_W-1:0]  rr_ptr_q;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              load;
    logic              xfer;
    logic [NUM_IN-1:0] ready_vec;
    logic [WIDTH-1:0]  sel_data;
    logic [IW-1:0]     rr_idx;

    assign load          = (state_q == EMPTY) || bus.out_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.in_ready  = ready_vec;
    assign xfer          = |(bus.in_valid & ready_vec);

    // Grant: requested channel in fixed mode, first valid channel from rr_ptr in round-robin mode.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = '0;
        if (!bus.mode) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if ((IW'(bus.select) == IW'(i)) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                rr_idx = IW'(rr_ptr_q) + IW'(k);
                if (rr_idx >= IW'(NUM_IN)) begin
                    rr_idx = rr_idx - IW'(NUM_IN);
                end
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    if (!grant_vld && (rr_idx == IW'(i)) && bus.in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    // One-hot accept to the granted channel, suppressed while in reset.
    always_comb begin
        ready_vec = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            ready_vec[i] = !rst && load && grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    // Data word of the granted channel.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage next state: fill on transfer, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (bus.out_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output word, source index and round-robin pointer update on transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mux_out <= '0;
            bus.out_sel <= '0;
            rr_ptr_q    <= '0;
        end else if (xfer) begin
            bus.mux_out <= sel_data;
            bus.out_sel <= grant_idx;
            if (bus.mode) begin
                rr_ptr_q <= (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end
endmodule
